// File: rtl/day3_batch_sequencer.sv
// day3_batch_sequencer: buffers battery-bank lines and streams digit columns into the day3 unit array, accumulating batch sums
module day3_batch_sequencer #(
  parameter int NUM_UNITS = 200,
  parameter int MAX_LEN = 128,
  parameter int UNIT_SUM_W = NUM_UNITS + 7,
  parameter int TOTAL_W = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic [7:0] in_data,
  input  logic in_last,
  output logic [4*NUM_UNITS-1:0] next_battery,
  output logic en,
  output logic unit_clear,
  input  logic [UNIT_SUM_W-1:0] joltage_sum,
  output logic [TOTAL_W-1:0] total,
  output logic done,
  output logic err
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int RW = $clog2(NUM_UNITS + 1);
  localparam int DW = 4 * NUM_UNITS;
  localparam int SW = TOTAL_W > UNIT_SUM_W ? TOTAL_W : UNIT_SUM_W;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, ACCUM, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [MAX_LEN];
  logic [DW-1:0] rd_q, mask;
  logic [CW-1:0] col, line_len, cnt, len_c;
  logic [RW-1:0] row, row_n;
  logic last_seen, last_n, acc, is_dig, is_nl, is_cr, dig_wr, close, bad, go;
  // units at or beyond the filled row count see digit 0 in a partial batch
  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_mask
    assign mask[4*g +: 4] = {4{row > RW'(g)}};
  end
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // byte classification and the effect of an accepted byte on the line/row counters
  always_comb begin
    go = start && (state == IDLE || state == DONE);
    acc = state == LOAD && in_valid;
    is_dig = in_data >= 8'h30 && in_data <= 8'h39;
    is_nl = in_data == 8'h0A;
    is_cr = in_data == 8'h0D;
    dig_wr = acc && is_dig && col != CW'(MAX_LEN);
    len_c = col + CW'(dig_wr);
    close = acc && (is_nl || in_last) && len_c != '0;
    bad = acc && ((is_dig && !dig_wr) || !(is_dig || is_nl || is_cr) || (close && row != '0 && len_c != line_len));
    row_n = row + RW'(close);
    last_n = last_seen || (acc && in_last);
  end
  // next-state logic; LOAD looks at the post-byte row count so no extra byte slips in
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? LOAD : state;
      LOAD: state_n = (row_n == RW'(NUM_UNITS) || (last_n && row_n != '0)) ? RUN : last_n ? DONE : LOAD;
      RUN: state_n = cnt == line_len ? DRAIN : RUN;
      DRAIN: state_n = cnt == CW'(DRAIN_CYCLES - 1) ? ACCUM : DRAIN;
      ACCUM: state_n = last_seen ? DONE : LOAD;
      default: state_n = IDLE;
    endcase
  end
  // outputs; en lags the read address by one cycle because the buffer read is registered
  always_comb begin
    in_ready = state == LOAD;
    en = state == RUN && cnt != '0;
    next_battery = en ? rd_q & mask : '0;
    unit_clear = state == ACCUM;
    done = state == DONE;
  end
  // column buffer: one nibble written per accepted digit, whole column read per cycle
  always_ff @(posedge clock) begin
    if (dig_wr) mem[col[AW-1:0]][{row, 2'b00} +: 4] <= in_data[3:0];
    if (state == RUN && cnt < line_len) rd_q <= mem[cnt[AW-1:0]];
  end
  // line/row bookkeeping, error flag and running total
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      col <= '0;
      row <= '0;
      line_len <= '0;
      last_seen <= 1'b0;
      err <= 1'b0;
      total <= '0;
    end else begin
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      if (go) begin
        col <= '0;
        row <= '0;
        line_len <= '0;
        last_seen <= 1'b0;
        err <= 1'b0;
        total <= '0;
      end else if (state == LOAD) begin
        col <= close ? '0 : len_c;
        row <= row_n;
        line_len <= close && row == '0 ? len_c : line_len;
        last_seen <= last_n;
        err <= err | bad;
      end else if (state == ACCUM) begin
        col <= '0;
        row <= '0;
        total <= TOTAL_W'(SW'(total) + SW'(joltage_sum));
      end
    end
endmodule
